// File: rtl/cpu7_ifu_ibuf_if.sv
`default_nettype none
//============================================================================
// Module      : cpu7_ifu_ibuf_if
// Description : Handshake bundle around the instruction buffer. It carries
//               the fetch-side push port, the decode-side head port, the
//               redirect flush and the occupancy count.
//               Modport slave  : the buffer itself.
//               Modport master : the environment (fetch + decode + exu).
//               Signals:
//                 fdp_ibuf_valid_f / fdp_ibuf_inst_f / fdp_ibuf_pc_f
//                                     fetch -> buffer
//                 ibuf_fdp_ready_f    buffer -> fetch
//                 ibuf_dec_valid_d / ibuf_dec_inst_d / ibuf_dec_pc_d
//                                     buffer -> decode
//                 dec_ibuf_ready_d    decode -> buffer
//                 exu_ibuf_flush      exu    -> buffer
//                 ibuf_cnt            buffer occupancy
// Revision    : 1.0 - initial release
//============================================================================
`ifndef GRLEN
`define GRLEN 32
`endif

interface cpu7_ifu_ibuf_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = `GRLEN
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            fdp_ibuf_valid_f;
    logic [31:0]     fdp_ibuf_inst_f;
    logic [PC_W-1:0] fdp_ibuf_pc_f;
    logic            ibuf_fdp_ready_f;
    logic            ibuf_dec_valid_d;
    logic [31:0]     ibuf_dec_inst_d;
    logic [PC_W-1:0] ibuf_dec_pc_d;
    logic            dec_ibuf_ready_d;
    logic            exu_ibuf_flush;
    logic [CW-1:0]   ibuf_cnt;

    modport slave (
        input  fdp_ibuf_valid_f,
        input  fdp_ibuf_inst_f,
        input  fdp_ibuf_pc_f,
        output ibuf_fdp_ready_f,
        output ibuf_dec_valid_d,
        output ibuf_dec_inst_d,
        output ibuf_dec_pc_d,
        input  dec_ibuf_ready_d,
        input  exu_ibuf_flush,
        output ibuf_cnt
    );

    modport master (
        output fdp_ibuf_valid_f,
        output fdp_ibuf_inst_f,
        output fdp_ibuf_pc_f,
        input  ibuf_fdp_ready_f,
        input  ibuf_dec_valid_d,
        input  ibuf_dec_inst_d,
        input  ibuf_dec_pc_d,
        output dec_ibuf_ready_d,
        output exu_ibuf_flush,
        input  ibuf_cnt
    );
endinterface

`default_nettype wire

// File: rtl/cpu7_ifu_ibuf.sv
`default_nettype none
//============================================================================
// Module      : cpu7_ifu_ibuf
// Description : Instruction buffer between fetch and decode. A DEPTH-entry
//               FIFO of {inst, pc} pairs lets fetch keep running while
//               decode stalls. The oldest entry is presented to decode with
//               a valid/ready handshake; a redirect flush empties it.
//               Optional feature macro: CPU7_IBUF_BYPASS_EN
//                 defined   : when empty, fetch data is forwarded to decode
//                             in the same cycle (zero-cycle latency).
//                 undefined : head data comes only from storage (one-cycle
//                             minimum latency, no fetch->decode comb path).
// Ports       : clk   - sole clock, rising edge
//               reset - synchronous, active-high
//               ibuf  - cpu7_ifu_ibuf_if.slave (fetch push port, decode
//                       head port, flush, occupancy count)
// Revision    : 1.0 - initial release
//============================================================================
`ifndef GRLEN
`define GRLEN 32
`endif

module cpu7_ifu_ibuf #(
    parameter int DEPTH = 4,
    parameter int PC_W  = `GRLEN
) (
    input  wire logic          clk,
    input  wire logic          reset,
    cpu7_ifu_ibuf_if.slave     ibuf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] C_CNT_ZERO = '0;

    logic [31:0]     r_inst_mem [DEPTH];
    logic [PC_W-1:0] r_pc_mem   [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;

    logic            w_empty;
    logic            w_ready;
    logic            w_byp;
    logic            w_valid;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_inst;
    logic [PC_W-1:0] w_pc;

    assign w_empty = (r_cnt == C_CNT_ZERO);

    // Ready looks only at registered occupancy: a full buffer stays not-ready
    // even while decode pops, keeping decode ready out of the fetch path.
    assign w_ready = !reset && (r_cnt != C_CNT_FULL);

`ifdef CPU7_IBUF_BYPASS_EN
    // Forwarding is held off during reset: fetch is not accepted then, so a
    // forwarded word would be offered again and reach decode twice.
    assign w_byp = w_empty && ibuf.fdp_ibuf_valid_f && !reset && !ibuf.exu_ibuf_flush;
`else
    assign w_byp = 1'b0;
`endif

    always_comb begin
        w_valid = (!w_empty || w_byp) && !ibuf.exu_ibuf_flush;
        w_inst  = '0;
        w_pc    = '0;
        if (w_byp) begin
            w_inst = ibuf.fdp_ibuf_inst_f;
            w_pc   = ibuf.fdp_ibuf_pc_f;
        end else if (w_valid) begin
            w_inst = r_inst_mem[r_rp];
            w_pc   = r_pc_mem[r_rp];
        end
        // A forwarded word that decode takes is never stored.
        w_push = ibuf.fdp_ibuf_valid_f && w_ready && !ibuf.exu_ibuf_flush
                 && !(w_byp && ibuf.dec_ibuf_ready_d);
        // Only a stored head advances the read pointer.
        w_pop  = w_valid && !w_empty && ibuf.dec_ibuf_ready_d;
    end

    // Storage has no reset; pointers and count decide what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wp] <= ibuf.fdp_ibuf_inst_f;
            r_pc_mem[r_wp]   <= ibuf.fdp_ibuf_pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || ibuf.exu_ibuf_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ibuf.ibuf_fdp_ready_f = w_ready;
    assign ibuf.ibuf_dec_valid_d = w_valid;
    assign ibuf.ibuf_dec_inst_d  = w_inst;
    assign ibuf.ibuf_dec_pc_d    = w_pc;
    assign ibuf.ibuf_cnt         = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_cpu7_ifu_ibuf.sv
`default_nettype none
//============================================================================
// Module      : tb_cpu7_ifu_ibuf
// Description : Self-checking bench for cpu7_ifu_ibuf (default build, no
//               bypass). A reference queue holds the entries the buffer
//               should contain; expected head, ready, valid and count are
//               derived from it each cycle.
// Revision    : 1.0 - initial release
//============================================================================
module tb_cpu7_ifu_ibuf;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    typedef struct packed {
        logic [31:0]     inst;
        logic [PC_W-1:0] pc;
    } ent_t;

    logic clk;
    logic reset;

    cpu7_ifu_ibuf_if #(.DEPTH(DEPTH), .PC_W(PC_W)) bus ();

    cpu7_ifu_ibuf #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .ibuf  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t        mq[$];
    int          n_vec;
    int          n_err;
    int          n_out;
    logic [PC_W-1:0] f_pc;
    logic        acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [PC_W-1:0] pc);
        return pc ^ 32'hA5A5_0013;
    endfunction

    // One clock: drive inputs, check outputs mid-cycle, update reference.
    task automatic cycle(input logic fv, input logic [PC_W-1:0] pc, input logic dr,
                         input logic fl, input logic rs, output logic accepted);
        logic exp_rdy;
        logic exp_vld;
        ent_t head;
        reset                 = rs;
        bus.fdp_ibuf_valid_f  = fv;
        bus.fdp_ibuf_pc_f     = pc;
        bus.fdp_ibuf_inst_f   = inst_of(pc);
        bus.dec_ibuf_ready_d  = dr;
        bus.exu_ibuf_flush    = fl;
        @(negedge clk);
        exp_rdy = !rs && (mq.size() < DEPTH);
        exp_vld = (mq.size() != 0) && !fl;
        head    = '0;
        if (exp_vld) head = mq[0];
        chk("ready", 64'(bus.ibuf_fdp_ready_f), 64'(exp_rdy));
        chk("valid", 64'(bus.ibuf_dec_valid_d), 64'(exp_vld));
        chk("inst",  64'(bus.ibuf_dec_inst_d),  64'(head.inst));
        chk("pc",    64'(bus.ibuf_dec_pc_d),    64'(head.pc));
        chk("cnt",   64'(bus.ibuf_cnt),         64'(mq.size()));
        accepted = fv && exp_rdy && !fl && !rs;
        if (rs || fl) begin
            mq.delete();
        end else begin
            if (exp_vld && dr) begin
                void'(mq.pop_front());
                n_out++;
            end
            if (accepted) mq.push_back('{inst: inst_of(pc), pc: pc});
        end
        @(posedge clk);
        #1;
    endtask

    // Present a stream of sequential PCs for ncyc cycles, holding each until
    // accepted. dr_mode: 0 decode stalled, 1 decode ready, 2 random.
    task automatic feed(input int ncyc, input int dr_mode);
        logic a;
        logic dr;
        for (int i = 0; i < ncyc; i++) begin
            dr = (dr_mode == 1) ? 1'b1 : (dr_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            cycle(1'b1, f_pc, dr, 1'b0, 1'b0, a);
            if (a) f_pc = f_pc + 32'd4;
        end
    endtask

    task automatic idle(input int ncyc, input logic dr);
        logic a;
        for (int i = 0; i < ncyc; i++) cycle(1'b0, '0, dr, 1'b0, 1'b0, a);
    endtask

    initial begin
        int sent;
        int guard;
        n_vec = 0;
        n_err = 0;
        n_out = 0;
        reset                = 1'b1;
        bus.fdp_ibuf_valid_f = 1'b0;
        bus.fdp_ibuf_inst_f  = '0;
        bus.fdp_ibuf_pc_f    = '0;
        bus.dec_ibuf_ready_d = 1'b0;
        bus.exu_ibuf_flush   = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        idle(1, 1'b0);

        // Single push with decode ready: head appears one cycle later
        cycle(1'b1, 32'h1c00_0000, 1'b1, 1'b0, 1'b0, acc);
        chk("first_acc", 64'(acc), 64'(1));
        idle(2, 1'b1);

        // Fill with decode stalled; fifth attempt refused until after a pop
        f_pc = 32'h0000_0200;
        feed(5, 0);
        chk("full_cnt", 64'(bus.ibuf_cnt), 64'(DEPTH));
        feed(1, 1);
        feed(1, 0);
        chk("fifth_in", 64'(f_pc), 64'(32'h0000_0214));
        idle(5, 1'b1);

        // Fill four, then concurrent push/pop across pointer wrap
        f_pc = 32'h0000_0100;
        feed(4, 0);
        feed(8, 1);
        idle(6, 1'b1);

        // Flush with push and pop active
        f_pc = 32'h0000_0300;
        feed(3, 0);
        cycle(1'b1, 32'h0000_0bad, 1'b1, 1'b1, 1'b0, acc);
        idle(2, 1'b1);

        // Reset with two entries held
        f_pc = 32'h0000_0400;
        feed(2, 0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, acc);
        idle(2, 1'b1);

        // Random decode stalls against continuous fetch
        n_out = 0;
        sent  = 0;
        guard = 0;
        f_pc  = 32'h1c00_1000;
        while (sent < 200 && guard < 5000) begin
            logic [PC_W-1:0] p0;
            p0 = f_pc;
            feed(1, 2);
            if (f_pc != p0) sent++;
            guard++;
        end
        guard = 0;
        while (mq.size() != 0 && guard < 100) begin
            idle(1, 1'b1);
            guard++;
        end
        chk("rand_sent", 64'(sent), 64'(200));
        chk("rand_out", 64'(n_out), 64'(200));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
